// File: rtl/host_pkt_filter_module.sv
// host_pkt_filter_module
//   Host-rx mapped-packet filter. Collects META_CYC leading metadata words of
//   each packet into a shift register. When the check field (low CHK_W bits
//   of the metadata) is all zero the metadata is stripped, the ctrl field
//   (top CTRL_W bits) is presented on ov_ctrl_data and the payload is
//   forwarded with one cycle of latency. Otherwise the packet is discarded.
//   A tail flag inside the metadata aborts the packet.
//
// Optional feature macro: PKT_FILTER_STAT_EN
//   defined     : pass / discard / error statistics counters implemented
//   not defined : counters removed, ov_*_cnt tied to zero
//
// Ports
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   iv_data          input word, bit DW = tail flag
//   i_data_wr        input word valid (gaps allowed)
//   ov_data          output word, bit DW set on first payload word and tail
//   o_data_wr        output word valid
//   ov_ctrl_data     ctrl field of the packet being forwarded
//   ov_state         FSM state (debug)
//   ov_pass_cnt      packets forwarded
//   ov_disc_cnt      packets discarded (check field non-zero)
//   ov_err_cnt       packets aborted (tail inside metadata)

module host_pkt_filter_module #(
  parameter int DW       = 8,
  parameter int META_CYC = 8,
  parameter int CTRL_W   = 19,
  parameter int CHK_W    = 45,
  parameter int CNT_W    = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [DW:0]       iv_data,
  input  logic              i_data_wr,
  output logic [DW:0]       ov_data,
  output logic              o_data_wr,
  output logic [CTRL_W-1:0] ov_ctrl_data,
  output logic [2:0]        ov_state,
  output logic [CNT_W-1:0]  ov_pass_cnt,
  output logic [CNT_W-1:0]  ov_disc_cnt,
  output logic [CNT_W-1:0]  ov_err_cnt
);

  localparam int MW = META_CYC * DW;
  localparam int CW = $clog2(META_CYC + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_META  = 3'd1;
  localparam logic [2:0] S_FIRST = 3'd2;
  localparam logic [2:0] S_TRANS = 3'd3;
  localparam logic [2:0] S_DISC  = 3'd4;

  // True when the check field of a metadata image is all zero.
  function automatic logic chk_zero(input logic [MW-1:0] meta);
    return (meta[CHK_W-1:0] == {CHK_W{1'b0}});
  endfunction

  logic [2:0]        state_r,  state_s;
  logic [MW-1:0]     meta_r,   meta_s;
  logic [CW-1:0]     cnt_r,    cnt_s;
  logic [DW:0]       data_r,   data_s;
  logic              wr_r,     wr_s;
  logic [CTRL_W-1:0] ctrl_r,   ctrl_s;

  logic [MW-1:0]     meta_shift_s;
  logic [CW-1:0]     cnt_inc_s;
  logic              tail_s;

  assign meta_shift_s = {meta_r[MW-DW-1:0], iv_data[DW-1:0]};
  assign cnt_inc_s    = cnt_r + CW'(1);
  assign tail_s       = iv_data[DW];

  // Next-state, metadata collection and output word selection.
  // In DISC, cnt is reused as a "first payload word seen" marker.
  always_comb begin
    state_s = state_r;
    meta_s  = meta_r;
    cnt_s   = cnt_r;
    data_s  = data_r;
    wr_s    = 1'b0;
    ctrl_s  = ctrl_r;
    case (state_r)
      S_IDLE: begin
        if (i_data_wr && !tail_s) begin
          meta_s  = meta_shift_s;
          cnt_s   = CW'(1);
          state_s = S_META;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_META: begin
        if (i_data_wr) begin
          if (tail_s) begin
            cnt_s   = CW'(0);
            state_s = S_IDLE;
          end else begin
            meta_s = meta_shift_s;
            if (cnt_inc_s == CW'(META_CYC)) begin
              cnt_s   = CW'(0);
              state_s = chk_zero(meta_shift_s) ? S_FIRST : S_DISC;
            end else begin
              cnt_s = cnt_inc_s;
            end
          end
        end else begin
          state_s = S_META;
        end
      end
      S_FIRST: begin
        if (i_data_wr) begin
          data_s  = {1'b1, iv_data[DW-1:0]};
          wr_s    = 1'b1;
          ctrl_s  = meta_r[MW-1 -: CTRL_W];
          state_s = tail_s ? S_IDLE : S_TRANS;
        end else begin
          state_s = S_FIRST;
        end
      end
      S_TRANS: begin
        if (i_data_wr) begin
          data_s  = iv_data;
          wr_s    = 1'b1;
          state_s = tail_s ? S_IDLE : S_TRANS;
        end else begin
          state_s = S_TRANS;
        end
      end
      S_DISC: begin
        if (i_data_wr) begin
          if (tail_s) begin
            cnt_s   = CW'(0);
            state_s = S_IDLE;
          end else begin
            cnt_s = CW'(1);
          end
        end else begin
          state_s = S_DISC;
        end
      end
      default: begin
        state_s = S_IDLE;
        cnt_s   = CW'(0);
        data_s  = {(DW+1){1'b0}};
        ctrl_s  = {CTRL_W{1'b0}};
      end
    endcase
  end

  // State, metadata and registered output words.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r <= S_IDLE;
      meta_r  <= {MW{1'b0}};
      cnt_r   <= CW'(0);
      data_r  <= {(DW+1){1'b0}};
      wr_r    <= 1'b0;
      ctrl_r  <= {CTRL_W{1'b0}};
    end else begin
      state_r <= state_s;
      meta_r  <= meta_s;
      cnt_r   <= cnt_s;
      data_r  <= data_s;
      wr_r    <= wr_s;
      ctrl_r  <= ctrl_s;
    end
  end

  assign ov_data      = data_r;
  assign o_data_wr    = wr_r;
  assign ov_ctrl_data = ctrl_r;
  assign ov_state     = state_r;

`ifdef PKT_FILTER_STAT_EN
  logic [CNT_W-1:0] pass_cnt_r, disc_cnt_r, err_cnt_r;
  logic             pass_inc_s, disc_inc_s, err_inc_s;

  // Exactly one of these fires once per packet: pass on the first payload
  // word, discard on the first dropped payload word, error on a tail that
  // arrives before the metadata is complete.
  always_comb begin
    pass_inc_s = i_data_wr && (state_r == S_FIRST);
    disc_inc_s = i_data_wr && (state_r == S_DISC) && (cnt_r == CW'(0));
    err_inc_s  = i_data_wr && tail_s &&
                 ((state_r == S_IDLE) || (state_r == S_META));
  end

  // Statistics counters, free-running wrap.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pass_cnt_r <= {CNT_W{1'b0}};
      disc_cnt_r <= {CNT_W{1'b0}};
      err_cnt_r  <= {CNT_W{1'b0}};
    end else begin
      if (pass_inc_s) pass_cnt_r <= pass_cnt_r + CNT_W'(1);
      else            pass_cnt_r <= pass_cnt_r;
      if (disc_inc_s) disc_cnt_r <= disc_cnt_r + CNT_W'(1);
      else            disc_cnt_r <= disc_cnt_r;
      if (err_inc_s)  err_cnt_r  <= err_cnt_r + CNT_W'(1);
      else            err_cnt_r  <= err_cnt_r;
    end
  end

  assign ov_pass_cnt = pass_cnt_r;
  assign ov_disc_cnt = disc_cnt_r;
  assign ov_err_cnt  = err_cnt_r;
`else
  assign ov_pass_cnt = {CNT_W{1'b0}};
  assign ov_disc_cnt = {CNT_W{1'b0}};
  assign ov_err_cnt  = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_host_pkt_filter_module.sv
// Testbench for host_pkt_filter_module: directed cases plus random packets,
// scoreboard queue filled by the driver and drained by an output monitor.
// A second instance with CNT_W=4 sees the same stimulus to exercise wrap.

module tb_host_pkt_filter_module;

  localparam int MC     = 8;
  localparam int CTRL_W = 19;
  localparam int CHK_W  = 45;
`ifdef PKT_FILTER_STAT_EN
  localparam bit STAT_EN = 1'b1;
`else
  localparam bit STAT_EN = 1'b0;
`endif

  localparam logic [63:0] M1 = 64'hABCD_E000_0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [8:0]  din;
  logic        wr;

  logic [8:0]  ov_data0, ov_data1;
  logic        o_wr0, o_wr1;
  logic [18:0] ctrl0, ctrl1;
  logic [2:0]  state0, state1;
  logic [15:0] pass0, disc0, err0;
  logic [3:0]  pass1, disc1, err1;

  host_pkt_filter_module dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .iv_data(din), .i_data_wr(wr),
    .ov_data(ov_data0), .o_data_wr(o_wr0), .ov_ctrl_data(ctrl0),
    .ov_state(state0), .ov_pass_cnt(pass0), .ov_disc_cnt(disc0),
    .ov_err_cnt(err0));

  host_pkt_filter_module #(.CNT_W(4)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .iv_data(din), .i_data_wr(wr),
    .ov_data(ov_data1), .o_data_wr(o_wr1), .ov_ctrl_data(ctrl1),
    .ov_state(state1), .ov_pass_cnt(pass1), .ov_disc_cnt(disc1),
    .ov_err_cnt(err1));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [8:0]  data;
    logic        first;
    logic [18:0] ctrl;
    int          at;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] fixed_pay[$];
  int n_checks = 0;
  int n_pass   = 0;
  int m_pass = 0, m_disc = 0, m_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [63:0] exp_cnt(input int n, input int w);
    return STAT_EN ? 64'(n % (1 << w)) : 64'd0;
  endfunction

  // Output monitor: every valid output word must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && o_wr0 === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_out: got word %0h, expected no output (t=%0t)", ov_data0, $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("out_data", 64'(ov_data0), 64'(e.data));
        chk("out_cycle", 64'(cyc), 64'(e.at));
        if (e.first) chk("out_ctrl", 64'(ctrl0), 64'(e.ctrl));
      end
    end
  end

  // One word, preceded by a random number of gap cycles in [gmin,gmax].
  task automatic send_word(input logic [8:0] d, input int gmin, input int gmax, output int at);
    int g;
    g = $urandom_range(gmax, gmin);
    repeat (g) begin
      @(negedge clk);
      wr  = 1'b0;
      din = 9'($urandom);
    end
    @(negedge clk);
    wr  = 1'b1;
    din = d;
    at  = cyc + 1;
  endtask

  // Whole packet. tail_idx >= 0 puts the tail on that metadata word.
  // stop_after >= 0 stops after that many words (for the mid-packet reset).
  task automatic send_pkt(input logic [63:0] meta, input int npay, input int tail_idx,
                          input int gmin, input int gmax, input int stop_after);
    int sent = 0;
    int at;
    bit pass;
    logic [7:0] p;
    logic [8:0] d;
    exp_t e;
    pass = (meta[CHK_W-1:0] == '0);
    for (int i = 0; i < MC; i++) begin
      if (stop_after >= 0 && sent >= stop_after) return;
      d = {(i == tail_idx), meta[63-8*i -: 8]};
      send_word(d, gmin, gmax, at);
      sent++;
      if (i == tail_idx) begin
        m_err++;
        return;
      end
    end
    for (int j = 0; j < npay; j++) begin
      if (stop_after >= 0 && sent >= stop_after) return;
      p = (fixed_pay.size() > 0) ? fixed_pay[j] : 8'($urandom);
      d = {(j == npay - 1), p};
      send_word(d, gmin, gmax, at);
      sent++;
      if (j == 0) begin
        if (pass) m_pass++;
        else      m_disc++;
      end
      if (pass) begin
        e.data  = (j == 0) ? {1'b1, p} : d;
        e.first = (j == 0);
        e.ctrl  = meta[63 -: CTRL_W];
        e.at    = at;
        exp_q.push_back(e);
      end
    end
  endtask

  // One idle cycle, then compare counters and state against the model.
  task automatic idle_check(input string tag);
    @(negedge clk);
    wr  = 1'b0;
    din = 9'($urandom);
    chk({tag, "_state"}, 64'(state0), 64'd0);
    chk({tag, "_pass"},  64'(pass0),  exp_cnt(m_pass, 16));
    chk({tag, "_disc"},  64'(disc0),  exp_cnt(m_disc, 16));
    chk({tag, "_err"},   64'(err0),   exp_cnt(m_err, 16));
    chk({tag, "_pass4"}, 64'(pass1),  exp_cnt(m_pass, 4));
    chk({tag, "_disc4"}, 64'(disc1),  exp_cnt(m_disc, 4));
    chk({tag, "_err4"},  64'(err1),   exp_cnt(m_err, 4));
  endtask

  task automatic reset_values(input string tag);
    chk({tag, "_data"},  64'(ov_data0), 64'd0);
    chk({tag, "_wr"},    64'(o_wr0),    64'd0);
    chk({tag, "_ctrl"},  64'(ctrl0),    64'd0);
    chk({tag, "_state"}, 64'(state0),   64'd0);
    chk({tag, "_pass"},  64'(pass0),    64'd0);
    chk({tag, "_disc"},  64'(disc0),    64'd0);
    chk({tag, "_err"},   64'(err0),     64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] meta;
    int kind, npay, gmax;
    bit b2b;

    rst_n = 1'b0;
    wr    = 1'b0;
    din   = 9'd0;
    repeat (3) @(negedge clk);
    reset_values("reset");
    rst_n = 1'b1;
    idle_check("post_reset");

    // Case 1: passing packet 11,22,33
    fixed_pay = '{8'h11, 8'h22, 8'h33};
    send_pkt(M1, 3, -1, 0, 0, -1);
    idle_check("case1");
    chk("case1_ctrl", 64'(ctrl0), 64'h55E6F);

    // Case 2: check field non-zero, five payload words discarded
    fixed_pay.delete();
    send_pkt(M1 | 64'h1, 5, -1, 0, 0, -1);
    idle_check("case2");

    // Case 3: tail on metadata word 4, then a normal packet
    send_pkt(M1, 3, 4, 0, 0, -1);
    idle_check("case3_abort");
    fixed_pay = '{8'h11, 8'h22, 8'h33};
    send_pkt(M1, 3, -1, 0, 0, -1);
    idle_check("case3_next");

    // Single-word packet: tail in IDLE
    send_pkt(M1, 3, 0, 0, 0, -1);
    idle_check("tail_idle");

    // Case 4: two gap cycles before every word
    send_pkt(M1, 3, -1, 2, 2, -1);
    idle_check("case4");

    // Case 5: back-to-back packets, then reset in the middle of a third
    send_pkt(M1, 3, -1, 0, 0, -1);
    send_pkt(M1, 3, -1, 0, 0, -1);
    idle_check("case5_b2b");
    send_pkt(M1, 3, -1, 0, 0, 9);
    @(negedge clk);
    wr = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    reset_values("mid_reset");
    chk("mid_reset_queue", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    m_pass = 0;
    m_disc = 0;
    m_err  = 0;
    @(negedge clk);
    rst_n = 1'b1;
    idle_check("after_reset");

    // Random traffic
    fixed_pay.delete();
    for (int k = 0; k < 90; k++) begin
      kind = $urandom_range(3, 0);
      npay = $urandom_range(5, 1);
      gmax = ($urandom_range(2, 0) == 0) ? 2 : 0;
      b2b  = ($urandom_range(2, 0) == 0);
      meta = {32'($urandom), 32'($urandom)};
      if (kind <= 1) begin
        meta = meta & 64'hFFFF_E000_0000_0000;
        send_pkt(meta, npay, -1, 0, gmax, -1);
      end else if (kind == 2) begin
        if (meta[CHK_W-1:0] == '0) meta[0] = 1'b1;
        send_pkt(meta, npay, -1, 0, gmax, -1);
      end else begin
        send_pkt(meta, npay, $urandom_range(MC - 1, 0), 0, gmax, -1);
      end
      if (!b2b) idle_check("rand");
    end
    idle_check("final");
    repeat (3) @(negedge clk);
    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
